// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W      = 64;
    localparam int OFFSET_W    = 3;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU-side request/response bus of the data memory
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_data_in;
    logic              control_memwrite;
    logic              control_memread;
    logic [WORD_W-1:0] mem_data_out;
    logic              mem_ready;
    logic              mem_error;

    modport master (
        output mem_address, mem_data_in, control_memwrite, control_memread,
        input  mem_data_out, mem_ready, mem_error
    );

    modport slave (
        input  mem_address, mem_data_in, control_memwrite, control_memread,
        output mem_data_out, mem_ready, mem_error
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 64 storage, synchronous write, asynchronous read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder: FSM, capture, checks
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    dmem_responder_if.slave   bus
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = WORD_W - OFFSET_W;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              rd_q;
    logic              wr_q;

    logic              req;
    logic              aligned;
    logic              in_range;
    logic              ok;
    logic              finishing;
    logic              commit_wr;
    logic [WORD_W-1:0] rdata;

    assign req       = bus.control_memread | bus.control_memwrite;
    assign aligned   = (addr_q[OFFSET_W-1:0] == '0);
    // Full-width compare so huge addresses never alias onto low indices
    assign in_range  = (addr_q[WORD_W-1:OFFSET_W] < WIDX_W'(DEPTH));
    assign ok        = aligned & in_range & ~(rd_q & wr_q);
    assign finishing = (state == BUSY) && (cnt == '0);
    // Reset on the commit edge must suppress the write
    assign commit_wr = finishing & ok & wr_q & ~RESET;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (CLOCK),
        .we    (commit_wr),
        .addr  (addr_q[OFFSET_W +: IDX_W]),
        .wdata (data_q),
        .rdata (rdata)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.mem_ready    <= 1'b0;
            bus.mem_error    <= 1'b0;
            bus.mem_data_out <= '0;
        end else begin
            case (state)
                // The edge closing RESP doubles as an accept edge for held requests
                IDLE, RESP: begin
                    bus.mem_ready <= 1'b0;
                    bus.mem_error <= 1'b0;
                    if (req) begin
                        addr_q <= bus.mem_address;
                        data_q <= bus.mem_data_in;
                        rd_q   <= bus.control_memread;
                        wr_q   <= bus.control_memwrite;
                        cnt    <= CNT_W'(LATENCY - 1);
                        state  <= BUSY;
                    end else begin
                        state  <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state         <= RESP;
                        bus.mem_ready <= 1'b1;
                        bus.mem_error <= ~ok;
                        if (ok && rd_q) begin
                            bus.mem_data_out <= rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
